fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 86 ++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: PC generation, DEPTH-entry {instr, pc} FIFO, redirect flush.
// Optional zero-latency bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   pc;
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          run;
   logic [31:0]   q_instr [DEPTH];
   logic [31:0]   q_pc    [DEPTH];

   logic fire, byp, push, pop;

   assign imem_req  = run && (count < CW'(DEPTH)) && !redirect;
   assign imem_addr = pc;
   assign fire      = imem_req && imem_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp       = fire && (count == '0);
   assign out_valid = (count != '0) || byp;
   assign out_instr = byp ? imem_rdata : q_instr[rptr];
   assign out_pc    = byp ? pc : q_pc[rptr];
`else
   assign byp       = 1'b0;
   assign out_valid = (count != '0);
   assign out_instr = q_instr[rptr];
   assign out_pc    = q_pc[rptr];
`endif

   // A bypassed instruction taken by decode the same cycle never enters the FIFO.
   assign push = fire && !(byp && out_ready);
   assign pop  = (count != '0) && out_ready && !redirect;

   // Holds imem_req low until reset release has been seen at a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) run <= 1'b0;
      else        run <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc    <= RESET_PC;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (redirect) begin
         pc    <= redirect_addr & ~32'h3;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (fire) pc <= pc + 32'd4;
         if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
         if (pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !redirect) begin
         q_instr[wptr] <= imem_rdata;
         q_pc[wptr]    <= pc;
      end
   end

endmodule
